huff_enc_ctrl: RTL

- Front-end controller for huff_encoder. Accepts a raw character stream over a valid/ready handshake and builds a table of unique characters with their frequencies.
- Sorts the table by descending frequency, then sequences one encoder run: holds the encoder in reset, releases it, and waits for done with a timeout.
- Captures the encoded values and masks and presents them through a valid/ready result port.
- Sits between the byte source and huff_encoder; it is the only driver of the encoder's data_in, freq_in and reset.

---
 rtl/huff_pkg.sv | 35 +++
 rtl/huff_enc_ctrl_if.sv | 35 +++
 rtl/huff_sort_pass.sv | 22 ++
 rtl/huff_enc_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared constants and types for the Huffman encoder front-end controller.
package huff_pkg;

  localparam int MAX_CHAR_COUNT = 5;
  localparam int FREQ_W         = 3;
  localparam int TIMEOUT_CYCLES = 64;

  localparam int UNIQ_W = $clog2(MAX_CHAR_COUNT + 1);
  localparam int IDX_W  = $clog2(MAX_CHAR_COUNT);
  localparam int CODE_W = MAX_CHAR_COUNT * MAX_CHAR_COUNT;

  localparam logic [FREQ_W-1:0] FREQ_MAX = '1;

  // Bit positions inside the 4-bit err vector {timeout, single, saturate, overflow}
  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_SATURATE = 1;
  localparam int ERR_SINGLE   = 2;
  localparam int ERR_TIMEOUT  = 3;

  typedef struct packed {
    logic [7:0]        chr;
    logic [FREQ_W-1:0] freq;
  } huff_entry_t;

  typedef huff_entry_t [MAX_CHAR_COUNT-1:0] huff_table_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SORT,
    ST_WAIT_ENC,
    ST_RESULT
  } huff_ctrl_state_e;

endpackage

// File: rtl/huff_enc_ctrl_if.sv
// Bundles the character stream, encoder and result signals of the controller.
interface huff_enc_ctrl_if;
  import huff_pkg::*;

  logic                               char_valid;
  logic                               char_ready;
  logic [7:0]                         char_data;
  logic                               char_last;
  logic                               enc_reset;
  logic [MAX_CHAR_COUNT*8-1:0]        enc_data_in;
  logic [MAX_CHAR_COUNT*FREQ_W-1:0]   enc_freq_in;
  logic                               enc_done;
  logic [CODE_W-1:0]                  enc_value;
  logic [CODE_W-1:0]                  enc_mask;
  logic                               res_valid;
  logic                               res_ready;
  logic [CODE_W-1:0]                  res_value;
  logic [CODE_W-1:0]                  res_mask;
  logic [MAX_CHAR_COUNT*8-1:0]        res_chars;
  logic [UNIQ_W-1:0]                  res_uniq;
  logic [3:0]                         err;

  modport master (
    input  char_valid, char_data, char_last, enc_done, enc_value, enc_mask, res_ready,
    output char_ready, enc_reset, enc_data_in, enc_freq_in,
           res_valid, res_value, res_mask, res_chars, res_uniq, err
  );

  modport slave (
    output char_valid, char_data, char_last, enc_done, enc_value, enc_mask, res_ready,
    input  char_ready, enc_reset, enc_data_in, enc_freq_in,
           res_valid, res_value, res_mask, res_chars, res_uniq, err
  );

endinterface

// File: rtl/huff_sort_pass.sv
// One odd-even transposition pass: phase 0 compares pairs (0,1),(2,3)...,
// phase 1 compares (1,2),(3,4)... Higher frequency moves toward slot 0.
module huff_sort_pass
  import huff_pkg::*;
(
  input  huff_table_t in_tbl,
  input  logic        phase,
  output huff_table_t out_tbl
);

  // Swap only on strictly greater so equal frequencies keep arrival order
  always_comb begin
    out_tbl = in_tbl;
    for (int i = 0; i < MAX_CHAR_COUNT - 1; i++) begin
      if (((i % 2) == int'(phase)) && (in_tbl[i+1].freq > in_tbl[i].freq)) begin
        out_tbl[i]   = in_tbl[i+1];
        out_tbl[i+1] = in_tbl[i];
      end
    end
  end

endmodule

// File: rtl/huff_enc_ctrl.sv
// Front-end controller for huff_encoder: counts unique characters, sorts them
// by frequency, runs the encoder once and presents the captured codes.
module huff_enc_ctrl
  import huff_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_CYCLES
)(
  input logic            clk,
  input logic            reset,
  huff_enc_ctrl_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam int SC_W = $clog2(MAX_CHAR_COUNT + 1);

  huff_ctrl_state_e  state, state_next;
  huff_table_t       tbl, tbl_sorted;
  logic [UNIQ_W-1:0] uniq, uniq_after;
  logic [3:0]        err;
  logic [SC_W-1:0]   sort_cnt;
  logic [TO_W-1:0]   wait_cnt;
  logic [CODE_W-1:0] res_value, res_mask;
  logic [IDX_W-1:0]  hit_idx;
  logic              accept, hit, full, sort_last, wait_expired;
  logic [MAX_CHAR_COUNT*8-1:0]      chars_flat;
  logic [MAX_CHAR_COUNT*FREQ_W-1:0] freq_flat;

  assign accept       = bus.char_valid && bus.char_ready;
  assign full         = (uniq == UNIQ_W'(MAX_CHAR_COUNT));
  assign uniq_after   = (hit || full) ? uniq : uniq + 1'b1;
  assign sort_last    = (sort_cnt == SC_W'(MAX_CHAR_COUNT - 1));
  assign wait_expired = (wait_cnt == TO_W'(TIMEOUT - 1));

  // Look the incoming character up against every occupied slot
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
      if (!hit && (UNIQ_W'(i) < uniq) && (tbl[i].chr == bus.char_data)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  huff_sort_pass u_sort (
    .in_tbl  (tbl),
    .phase   (sort_cnt[0]),
    .out_tbl (tbl_sorted)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decision; a string with at most one unique character bypasses the encoder
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          if (bus.char_last)
            state_next = (uniq_after <= UNIQ_W'(1)) ? ST_RESULT : ST_SORT;
          else
            state_next = ST_COLLECT;
        end
      end
      ST_SORT:     if (sort_last) state_next = ST_WAIT_ENC;
      ST_WAIT_ENC: if (bus.enc_done || wait_expired) state_next = ST_RESULT;
      ST_RESULT:   if (bus.res_ready) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Table, counters, error flags and captured encoder results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl       <= '0;
      uniq      <= '0;
      err       <= '0;
      sort_cnt  <= '0;
      wait_cnt  <= '0;
      res_value <= '0;
      res_mask  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (accept) begin
            if (hit) begin
              if (tbl[hit_idx].freq == FREQ_MAX) err[ERR_SATURATE] <= 1'b1;
              else tbl[hit_idx].freq <= tbl[hit_idx].freq + 1'b1;
            end else if (!full) begin
              tbl[uniq[IDX_W-1:0]] <= '{chr: bus.char_data, freq: FREQ_W'(1)};
              uniq <= uniq + 1'b1;
            end else begin
              err[ERR_OVERFLOW] <= 1'b1;
            end
            if (bus.char_last && (uniq_after <= UNIQ_W'(1))) err[ERR_SINGLE] <= 1'b1;
            sort_cnt  <= '0;
            res_value <= '0;
            res_mask  <= '0;
          end
        end
        ST_SORT: begin
          tbl      <= tbl_sorted;
          sort_cnt <= sort_cnt + 1'b1;
          wait_cnt <= '0;
        end
        ST_WAIT_ENC: begin
          if (bus.enc_done) begin
            res_value <= bus.enc_value;
            res_mask  <= bus.enc_mask;
          end else if (wait_expired) begin
            err[ERR_TIMEOUT] <= 1'b1;
            res_value <= '0;
            res_mask  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            tbl       <= '0;
            uniq      <= '0;
            err       <= '0;
            res_value <= '0;
            res_mask  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten the table into the slot-per-byte encoder and result buses
  always_comb begin
    chars_flat = '0;
    freq_flat  = '0;
    for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
      chars_flat[8*i +: 8]          = tbl[i].chr;
      freq_flat[FREQ_W*i +: FREQ_W] = tbl[i].freq;
    end
  end

  assign bus.char_ready  = ((state == ST_IDLE) || (state == ST_COLLECT)) && !reset;
  assign bus.enc_reset   = (state != ST_WAIT_ENC);
  assign bus.enc_data_in = chars_flat;
  assign bus.enc_freq_in = freq_flat;
  assign bus.res_valid   = (state == ST_RESULT);
  assign bus.res_value   = res_value;
  assign bus.res_mask    = res_mask;
  assign bus.res_chars   = chars_flat;
  assign bus.res_uniq    = uniq;
  assign bus.err         = err;

endmodule
